// File: rtl/neuron_layer_sequencer.sv
// neuron_layer_sequencer
// Drives the sigmoid ALU through one fully-connected layer, one neuron at a time.
// For each neuron it clears the ALU, issues G = N_IN/4 weight/input group reads,
// raises alu_accumulate in step with the ALU pipeline, waits for the sigmoid
// result and emits it as (res_idx, res_data).
//
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   start             layer start pulse (honoured only while idle)
//   busy, done        status: busy outside IDLE, done pulses once per layer
//   w_addr / w_rdata  weight memory (neuron*G + group), 1-cycle read latency
//   x_addr / x_rdata  input buffer (group), 1-cycle read latency
//   b_addr / b_rdata  bias memory (current neuron), 1-cycle read latency
//   alu_weight, alu_input, alu_bias   read-data passthrough to the ALU
//   alu_accumulate, alu_clear         ALU control strobes
//   alu_out           registered 4-bit sigmoid output of the ALU
//   res_valid, res_idx, res_data      one-cycle result strobe with neuron index and value
module neuron_layer_sequencer #(
    parameter int N_IN    = 64,
    parameter int N_OUT   = 10,
    parameter int ACC_DLY = 4,
    parameter int OUT_DLY = 2,
    localparam int G      = N_IN / 4,
    localparam int WAW    = ((N_OUT * G) > 1) ? $clog2(N_OUT * G) : 1,
    localparam int XAW    = (G > 1) ? $clog2(G) : 1,
    localparam int NW     = (N_OUT > 1) ? $clog2(N_OUT) : 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    output logic           busy,
    output logic           done,
    output logic [WAW-1:0] w_addr,
    input  logic [15:0]    w_rdata,
    output logic [XAW-1:0] x_addr,
    input  logic [15:0]    x_rdata,
    output logic [NW-1:0]  b_addr,
    input  logic [3:0]     b_rdata,
    output logic [15:0]    alu_weight,
    output logic [15:0]    alu_input,
    output logic [3:0]     alu_bias,
    output logic           alu_accumulate,
    output logic           alu_clear,
    input  logic [3:0]     alu_out,
    output logic           res_valid,
    output logic [NW-1:0]  res_idx,
    output logic [3:0]     res_data
);

    // Drain covers the remaining accumulate latency plus the ALU output registers.
    localparam int DRAIN_N = ACC_DLY + OUT_DLY - 1;
    localparam int DW      = (DRAIN_N > 1) ? $clog2(DRAIN_N + 1) : 1;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CLEAR   = 3'd1,
        ST_ISSUE   = 3'd2,
        ST_DRAIN   = 3'd3,
        ST_CAPTURE = 3'd4,
        ST_DONE    = 3'd5
    } state_t;

    state_t             state_r;
    state_t             state_next_s;
    logic [NW-1:0]      neuron_r;
    logic [XAW-1:0]     group_r;
    logic [WAW-1:0]     w_addr_r;
    logic [DW-1:0]      drain_cnt_r;
    logic [ACC_DLY-1:0] issue_pipe_r;
    logic               busy_r;
    logic               done_r;
    logic               res_valid_r;
    logic [NW-1:0]      res_idx_r;
    logic [3:0]         res_data_r;

    logic               clear_s;
    logic               issue_s;
    logic               capture_s;
    logic               last_group_s;
    logic               last_drain_s;
    logic               last_neuron_s;

    assign last_group_s  = (group_r == XAW'(G - 1));
    assign last_drain_s  = (drain_cnt_r == DW'(DRAIN_N - 1));
    assign last_neuron_s = (neuron_r == NW'(N_OUT - 1));

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state decode.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_next_s = ST_CLEAR;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_CLEAR: state_next_s = ST_ISSUE;
            ST_ISSUE: begin
                if (last_group_s) begin
                    state_next_s = ST_DRAIN;
                end else begin
                    state_next_s = ST_ISSUE;
                end
            end
            ST_DRAIN: begin
                if (last_drain_s) begin
                    state_next_s = ST_CAPTURE;
                end else begin
                    state_next_s = ST_DRAIN;
                end
            end
            ST_CAPTURE: begin
                if (last_neuron_s) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_CLEAR;
                end
            end
            ST_DONE: state_next_s = ST_IDLE;
            default: state_next_s = ST_IDLE;
        endcase
    end

    // State-decoded control strobes.
    always_comb begin
        clear_s   = 1'b0;
        issue_s   = 1'b0;
        capture_s = 1'b0;
        case (state_r)
            ST_CLEAR:   clear_s   = 1'b1;
            ST_ISSUE:   issue_s   = 1'b1;
            ST_CAPTURE: capture_s = 1'b1;
            default: begin
                clear_s   = 1'b0;
                issue_s   = 1'b0;
                capture_s = 1'b0;
            end
        endcase
    end

    // Counters, issue pipe, status and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            neuron_r     <= {NW{1'b0}};
            group_r      <= {XAW{1'b0}};
            w_addr_r     <= {WAW{1'b0}};
            drain_cnt_r  <= {DW{1'b0}};
            issue_pipe_r <= {ACC_DLY{1'b0}};
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            res_valid_r  <= 1'b0;
            res_idx_r    <= {NW{1'b0}};
            res_data_r   <= 4'd0;
        end else begin
            // Each issued group reaches the ALU accumulator exactly ACC_DLY cycles later.
            issue_pipe_r <= (issue_pipe_r << 1) | ACC_DLY'(issue_s);
            // busy/done are registered from the next state so they line up with the state itself.
            busy_r       <= (state_next_s != ST_IDLE);
            done_r       <= (state_next_s == ST_DONE);
            res_valid_r  <= capture_s;
            if (capture_s) begin
                res_idx_r  <= neuron_r;
                res_data_r <= alu_out;
            end
            case (state_r)
                ST_CLEAR: begin
                    group_r     <= {XAW{1'b0}};
                    w_addr_r    <= WAW'(neuron_r * G);
                    drain_cnt_r <= {DW{1'b0}};
                end
                ST_ISSUE: begin
                    // Hold on the last group so the address never steps past the layer.
                    if (!last_group_s) begin
                        group_r  <= group_r + XAW'(1);
                        w_addr_r <= w_addr_r + WAW'(1);
                    end
                end
                ST_DRAIN: begin
                    if (!last_drain_s) begin
                        drain_cnt_r <= drain_cnt_r + DW'(1);
                    end
                end
                ST_CAPTURE: begin
                    if (!last_neuron_s) begin
                        neuron_r <= neuron_r + NW'(1);
                    end
                end
                ST_DONE: neuron_r <= {NW{1'b0}};
                default: begin
                    neuron_r <= neuron_r;
                end
            endcase
        end
    end

    assign busy           = busy_r;
    assign done           = done_r;
    assign w_addr         = w_addr_r;
    assign x_addr         = group_r;
    assign b_addr         = neuron_r;
    assign alu_weight     = w_rdata;
    assign alu_input      = x_rdata;
    assign alu_bias       = b_rdata;
    assign alu_accumulate = issue_pipe_r[ACC_DLY-1];
    // Reset also zeroes the ALU accumulator.
    assign alu_clear      = rst | clear_s;
    assign res_valid      = res_valid_r;
    assign res_idx        = res_idx_r;
    assign res_data       = res_data_r;

endmodule

// File: tb/tb_neuron_layer_sequencer.sv
// Self-checking bench for neuron_layer_sequencer with default parameters.
// Contains memory and sigmoid-ALU models as environment; expected results come
// from a direct dot-product reference over the memory contents.
module tb_neuron_layer_sequencer;

    localparam int N_IN  = 64;
    localparam int N_OUT = 10;
    localparam int G     = N_IN / 4;
    localparam int PER   = G + 7;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        busy, done;
    logic [7:0]  w_addr;
    logic [15:0] w_rdata;
    logic [3:0]  x_addr;
    logic [15:0] x_rdata;
    logic [3:0]  b_addr;
    logic [3:0]  b_rdata;
    logic [15:0] alu_weight, alu_input;
    logic [3:0]  alu_bias;
    logic        alu_accumulate, alu_clear;
    logic [3:0]  alu_out;
    logic        res_valid;
    logic [3:0]  res_idx;
    logic [3:0]  res_data;

    logic [15:0] wmem [N_OUT*G];
    logic [15:0] xmem [G];
    logic [3:0]  bmem [N_OUT];

    int errors = 0;
    int checks = 0;
    int got [N_OUT];

    logic [15:0] r1_w, r1_x;
    int          r2, r3, acc;

    neuron_layer_sequencer dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .w_addr(w_addr), .w_rdata(w_rdata), .x_addr(x_addr), .x_rdata(x_rdata),
        .b_addr(b_addr), .b_rdata(b_rdata),
        .alu_weight(alu_weight), .alu_input(alu_input), .alu_bias(alu_bias),
        .alu_accumulate(alu_accumulate), .alu_clear(alu_clear), .alu_out(alu_out),
        .res_valid(res_valid), .res_idx(res_idx), .res_data(res_data)
    );

    always #5 clk = ~clk;

    function automatic int nib_w(logic [15:0] v, int k);
        logic [3:0] n;
        n = v[k*4 +: 4];
        return int'($signed(n));
    endfunction

    function automatic int nib_x(logic [15:0] v, int k);
        logic [3:0] n;
        n = v[k*4 +: 4];
        return int'(n);
    endfunction

    // Sigmoid approximation of the ALU: integer part of the 1/8-scaled sum plus bias, centred at 4.
    function automatic logic [3:0] sig(int a, logic [3:0] b);
        int v;
        v = (a >>> 3) + int'($signed(b)) + 4;
        if (v < 0) v = 0;
        if (v > 15) v = 15;
        return 4'(v);
    endfunction

    function automatic int group_dot(logic [15:0] w, logic [15:0] x);
        int s = 0;
        for (int k = 0; k < 4; k++) s += nib_w(w, k) * nib_x(x, k);
        return s;
    endfunction

    // Reference: plain dot product of neuron n over all N_IN inputs.
    function automatic int ref_out(int n);
        int dot = 0;
        for (int i = 0; i < N_IN; i++)
            dot += nib_w(wmem[n*G + i/4], i % 4) * nib_x(xmem[i/4], i % 4);
        return int'(sig(dot, bmem[n]));
    endfunction

    // Memory and ALU environment: 1-cycle reads, 3 ALU stages, accumulator, output register.
    always @(posedge clk) begin
        w_rdata <= wmem[w_addr];
        x_rdata <= xmem[x_addr];
        b_rdata <= bmem[b_addr];
        r1_w    <= alu_weight;
        r1_x    <= alu_input;
        r2      <= group_dot(r1_w, r1_x);
        r3      <= r2;
        if (alu_clear) acc <= 0;
        else if (alu_accumulate) acc <= acc + r3;
        alu_out <= sig(acc, alu_bias);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic load_random();
        for (int a = 0; a < N_OUT*G; a++) begin
            logic [15:0] w;
            for (int k = 0; k < 4; k++) begin
                int r;
                r = int'($urandom_range(0, 2));
                w[k*4 +: 4] = (r == 0) ? 4'hF : ((r == 1) ? 4'h0 : 4'h1);
            end
            wmem[a] = w;
        end
        for (int g = 0; g < G; g++) xmem[g] = 16'($urandom_range(0, 65535));
        for (int n = 0; n < N_OUT; n++) bmem[n] = 4'($urandom_range(0, 4)) - 4'd2;
    endtask

    // One layer run; k counts cycles after the edge that sampled start (k=0 is CLEAR of neuron 0).
    task automatic run_layer(input int abort_k, input bit poke);
        int n, p;
        bit in_layer;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 0; k <= PER*N_OUT + 10; k++) begin
            if (abort_k >= 0 && k == abort_k + 1) begin
                check("abort_busy", int'(busy), 0);
                check("abort_acc", int'(alu_accumulate), 0);
                check("abort_rv", int'(res_valid), 0);
                check("abort_done", int'(done), 0);
                rst = 1'b0;
                for (int j = 0; j < 30; j++) begin
                    step();
                    check("abort_idle_rv", int'(res_valid), 0);
                    check("abort_idle_acc", int'(alu_accumulate), 0);
                    check("abort_idle_busy", int'(busy), 0);
                end
                return;
            end
            in_layer = (k < PER*N_OUT);
            n = k / PER;
            p = k % PER;
            check("busy", int'(busy), (k <= PER*N_OUT) ? 1 : 0);
            check("done", int'(done), (k == PER*N_OUT) ? 1 : 0);
            check("alu_clear", int'(alu_clear), (in_layer && p == 0) ? 1 : 0);
            check("alu_accumulate", int'(alu_accumulate), (in_layer && p >= 5 && p <= G + 4) ? 1 : 0);
            check("res_valid", int'(res_valid), (k >= PER && k <= PER*N_OUT && p == 0) ? 1 : 0);
            if (in_layer && p >= 1 && p <= G) begin
                check("w_addr", int'(w_addr), n*G + p - 1);
                check("x_addr", int'(x_addr), p - 1);
            end
            if (in_layer && p >= 1) check("b_addr", int'(b_addr), n);
            if (k >= PER && k <= PER*N_OUT && p == 0) begin
                check("res_idx", int'(res_idx), n - 1);
                check("res_data", int'(res_data), ref_out(n - 1));
                got[n-1] = int'(res_data);
            end
            if (abort_k >= 0 && k == abort_k) rst = 1'b1;
            if (poke) start = (k == 5 || k == PER*N_OUT) ? 1'b1 : 1'b0;
            step();
        end
        start = 1'b0;
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        // Directed data: only the first four inputs are 1.0; weight patterns 1, -1, 0 by neuron.
        for (int n = 0; n < N_OUT; n++) begin
            bmem[n] = 4'd0;
            for (int g = 0; g < G; g++)
                wmem[n*G + g] = (n % 3 == 0) ? 16'h1111 : ((n % 3 == 1) ? 16'hFFFF : 16'h0000);
        end
        for (int g = 0; g < G; g++) xmem[g] = (g == 0) ? 16'h8888 : 16'h0000;

        for (int c = 0; c < 2; c++) begin
            step();
            check("rst_busy", int'(busy), 0);
            check("rst_done", int'(done), 0);
            check("rst_rv", int'(res_valid), 0);
            check("rst_acc", int'(alu_accumulate), 0);
            check("rst_clear", int'(alu_clear), 1);
            check("rst_res_idx", int'(res_idx), 0);
            check("rst_res_data", int'(res_data), 0);
            check("rst_w_addr", int'(w_addr), 0);
            check("rst_x_addr", int'(x_addr), 0);
            check("rst_b_addr", int'(b_addr), 0);
        end
        rst = 1'b0;
        step();
        check("post_rst_busy", int'(busy), 0);
        check("post_rst_clear", int'(alu_clear), 0);

        run_layer(-1, 1'b0);
        check("dir_w1", got[0], 4'b1000);
        check("dir_wF", got[1], 4'b0000);
        check("dir_w0", got[2], 4'b0100);

        load_random();
        step();
        run_layer(-1, 1'b1);
        step();
        run_layer(-1, 1'b0);
        run_layer(3*PER + 5, 1'b0);
        run_layer(-1, 1'b0);

        load_random();
        step();
        run_layer(-1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
